tt_um_addon_leg: RTL
====================

# tt_um_addon_leg

Multi-cycle Pythagorean leg solver, the inverse companion of the hypotenuse/magnitude tile. Given hypotenuse c and one leg a (both 8-bit unsigned), computes b = floor(sqrt(c² − a²)) with a registered handshake. It uses the standard Tiny Tapeout tile pinout. Operands are written over a shared 8-bit data bus, the root is computed bit-serially over 8 cycles, and the result is held on uo_out until the next start.

## Interface
- No parameters; iteration count is fixed by the package constant.
- clk  in  1  sole clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- ui_in  in  8  operand data bus (c or a, selected by write strobes)
- uio_in  in  8  control: [0] wr_c, [1] wr_a, [2] start; [7:3] ignored
- uo_out  out  8  result b, registered; reset 0
- uio_out  out  8  status: [4] busy, [5] done, [6] err; other bits 0; reset all 0
- uio_oe  out  8  constant 8'b0111_0000
- ena  in  1  ignored

## Operation
- FSM states: IDLE, DIFF, ROOT, DONE. Reset → IDLE. Reset clears c, a, rad, q, cnt and start_q; busy/done/err = 0; uo_out = 0.
- Operand writes are accepted in IDLE and DONE only:
  - wr_c = 1 loads c ← ui_in.
  - wr_a = 1 loads a ← ui_in.
  - Both strobes high loads both with the same value.
  - Writes in DIFF/ROOT are ignored.
- Start is rising-edge detected: start & ~start_q, with start_q registered every cycle. A level held high triggers once.
- In IDLE or DONE, a detected start:
  - state → DIFF, busy = 1, done = 0, err = 0; uo_out is retained.
  - A write and a start in the same cycle: the write lands first. The new operand is used.
- DIFF (1 cycle):
  - If a > c: err = 1, done = 1, busy = 0, uo_out = 0, state → DONE.
  - Otherwise: rad ← c*c − a*a (16-bit unsigned, max 65025, no overflow), q ← 0, rem ← 0, cnt ← 0, state → ROOT.
- ROOT (exactly 8 cycles): restoring digit-by-digit root, 2 radicand bits per cycle, MSB pair first. Per step:
  - rem' = (rem<<2) | rad[15:14]
  - trial = (q<<2) | 1
  - If rem' ≥ trial: rem = rem' − trial, q = (q<<1) | 1. Else rem = rem', q = q<<1.
  - rad shifts left by 2.
  - rem is 10 bits wide; q is 8 bits.
- After the 8th step: uo_out ← q, done = 1, busy = 0, state → DONE.
- Start while busy (DIFF/ROOT) is ignored, but start_q still tracks the pin.
- DONE holds uo_out, done and err until the next accepted start.

## Timing
- Start first seen high at edge N. Then:
  - busy = 1 after edge N.
  - DIFF evaluates at edge N+1.
  - ROOT steps occur at edges N+2 … N+9.
  - done = 1 and uo_out valid after edge N+9: 9 cycles start-to-done.
- Error path: done = 1, err = 1, uo_out = 0 after edge N+1.
- Minimum start-to-start spacing is 10 cycles; a back-to-back restart from DONE is permitted on the cycle after done rises.
- rst_n low at any edge aborts immediately to the reset state. The aborted result is never presented.

## Configuration
- LEG_ROUND_EN defined: the final step rounds to nearest.
  - If the final remainder > final q, the output is q + 1, saturating at 255.
  - Same cycle, no added latency.
- LEG_ROUND_EN undefined: the output is truncated (floor).
- The err behaviour is identical in both builds.

## Structure
- Package leg_pkg holds:
  - the state enum (IDLE, DIFF, ROOT, DONE)
  - ROOT_ITERS = 8
  - the uio bit indices (WR_C, WR_A, START, BUSY, DONE, ERR)
  - the UIO_OE_MASK constant
- Sub-module leg_isqrt: the iterative root core. It has load/step controls and rad/q/rem registers, and exposes q, rem and last-step. The top holds the operands, the DIFF stage, edge detect, status and output registers.

## Test plan
- c=5, a=3, start → after 9 cycles done=1, busy=0, err=0, uo_out=4.
- c=13, a=11 (rad 48) → uo_out=6; with LEG_ROUND_EN → 7.
- c=255, a=0 → uo_out=255 in both builds; c=10, a=10 → uo_out=0, err=0.
- c=3, a=7, start → done=1, err=1, uo_out=0 exactly 1 cycle after start.
- Mid-ROOT handling:
  - Start pulse plus wr_c=200 during ROOT → both ignored; the original result completes.
  - start held high 20 cycles → exactly one computation.
- rst_n low at ROOT cycle 4 → next edge uo_out=0, all status 0, state IDLE. A fresh run with c=5, a=4 → uo_out=3.

Source files
------------

// File: rtl/leg_pkg.sv
// leg_pkg: shared states, iteration count and uio bit map for the Pythagorean leg solver.
package leg_pkg;
    typedef enum logic [1:0] {IDLE, DIFF, ROOT, DONE} state_t;
    localparam int ROOT_ITERS = 8;
    localparam int UIO_WR_C = 0;
    localparam int UIO_WR_A = 1;
    localparam int UIO_START = 2;
    localparam int UIO_BUSY = 4;
    localparam int UIO_DONE = 5;
    localparam int UIO_ERR = 6;
    localparam logic [7:0] UIO_OE_MASK = 8'b0111_0000;
endpackage

// File: rtl/leg_isqrt.sv
// leg_isqrt: restoring bit-serial square root, two radicand bits per step.
module leg_isqrt import leg_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] rad_in,
    output logic [7:0]  q_nxt,
    output logic [9:0]  rem_nxt,
    output logic        last
);
    logic [15:0] rad;
    logic [7:0]  q;
    logic [9:0]  rem, rem_sh, trial;
    logic [2:0]  cnt;
    logic        fits;
    // q_nxt/rem_nxt are the results of the step taken at the coming edge
    always_comb begin
        rem_sh  = (rem << 2) | {8'b0, rad[15:14]};
        trial   = {q, 2'b01};
        fits    = rem_sh >= trial;
        rem_nxt = fits ? rem_sh - trial : rem_sh;
        q_nxt   = {q[6:0], fits};
        last    = cnt == 3'(ROOT_ITERS - 1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rad <= '0;
            q   <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (load) begin
            rad <= rad_in;
            q   <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (step) begin
            rad <= {rad[13:0], 2'b00};
            q   <= q_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 3'd1;
        end
    end
endmodule

// File: rtl/tt_um_addon_leg.sv
// tt_um_addon_leg: computes b = floor(sqrt(c*c - a*a)) over a Tiny Tapeout pinout.
// Define LEG_ROUND_EN to round the result to nearest instead of truncating.
module tt_um_addon_leg import leg_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
`ifdef LEG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    state_t      state, nxt;
    logic [7:0]  c, a, q_nxt, res;
    logic [9:0]  rem_nxt;
    logic [15:0] rad_in;
    logic        start_q, err, open, go, bad, load, last;
    logic        unused;
    assign unused = &{ena, uio_in[7:3]};
    assign uio_oe = UIO_OE_MASK;
    always_comb begin
        open   = state == IDLE || state == DONE;
        go     = open && uio_in[UIO_START] && !start_q;
        bad    = a > c;
        load   = state == DIFF && !bad;
        rad_in = {8'b0, c} * {8'b0, c} - {8'b0, a} * {8'b0, a};
        res    = (ROUND && rem_nxt > {2'b0, q_nxt} && q_nxt != 8'hff) ? q_nxt + 8'd1 : q_nxt;
        nxt    = state;
        if (open && go)
            nxt = DIFF;
        else if (state == DIFF)
            nxt = bad ? DONE : ROOT;
        else if (state == ROOT && last)
            nxt = DONE;
        uio_out            = '0;
        uio_out[UIO_BUSY]  = state == DIFF || state == ROOT;
        uio_out[UIO_DONE]  = state == DONE;
        uio_out[UIO_ERR]   = err;
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c       <= '0;
            a       <= '0;
            start_q <= 1'b0;
            err     <= 1'b0;
            uo_out  <= '0;
        end else begin
            start_q <= uio_in[UIO_START];
            if (open && uio_in[UIO_WR_C])
                c <= ui_in;
            if (open && uio_in[UIO_WR_A])
                a <= ui_in;
            if (go)
                err <= 1'b0;
            if (state == DIFF && bad) begin
                err    <= 1'b1;
                uo_out <= '0;
            end
            if (state == ROOT && last)
                uo_out <= res;
        end
    end
    leg_isqrt u_isqrt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (state == ROOT),
        .rad_in  (rad_in),
        .q_nxt   (q_nxt),
        .rem_nxt (rem_nxt),
        .last    (last)
    );
endmodule
